// File: rtl/rv0_fetch.sv
// rv0 instruction fetch stage: owns the PC, issues in-order word requests to
// instruction memory and buffers returned instructions for decode.
module rv0_fetch #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter int unsigned     IBUF_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] ct_target_i,
  input  logic            ct_trans_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     if_insn_o,
  output logic [XLEN-1:0] if_addr_o,
  output logic            if_valid_o,
  input  logic            if_ready_i
);

  localparam int unsigned     CW         = $clog2(2 * IBUF_DEPTH + 1);
  localparam int unsigned     PW         = $clog2(IBUF_DEPTH);
  localparam logic [CW-1:0]   DEPTH_C    = CW'(IBUF_DEPTH);
  localparam logic [CW-1:0]   MAX_ISSUED = CW'(2 * IBUF_DEPTH);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic {BOOT, RUN} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   issued_q, discard_q, issued_d, live, fifo_count_q;
  logic [XLEN-1:0] aq_mem [IBUF_DEPTH];
  logic [PW-1:0]   aq_rd_q, aq_wr_q;
  logic [31:0]     fifo_insn [IBUF_DEPTH];
  logic [XLEN-1:0] fifo_addr [IBUF_DEPTH];
  logic [PW-1:0]   fifo_rd_q, fifo_wr_q;
  logic            grant, resp, drop, push, pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= BOOT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Live outstanding requests plus buffered entries never exceed the buffer depth.
  assign live        = issued_q - discard_q;
  assign imem_req_o  = (state_q == RUN) && ((live + fifo_count_q) < DEPTH_C)
                       && (issued_q < MAX_ISSUED);
  assign imem_addr_o = pc_q & ALIGN_MASK;

  assign grant    = imem_req_o & imem_gnt_i;
  assign resp     = imem_rvalid_i & (issued_q != '0);
  assign drop     = resp & (discard_q != '0);
  assign push     = resp & ~drop & ~ct_trans_i;
  assign issued_d = issued_q + CW'(grant) - CW'(resp);

  assign if_valid_o = (fifo_count_q != '0) & ~ct_trans_i;
  assign pop        = if_valid_o & if_ready_i;
  assign if_insn_o  = fifo_insn[fifo_rd_q];
  assign if_addr_o  = fifo_addr[fifo_rd_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q      <= RESET_ADDR & ALIGN_MASK;
      issued_q  <= '0;
      discard_q <= '0;
    end else begin
      issued_q <= issued_d;
      if (ct_trans_i) begin
        pc_q      <= ct_target_i & ALIGN_MASK;
        discard_q <= issued_d;
      end else begin
        if (grant) pc_q <= pc_q + XLEN'(4);
        if (drop)  discard_q <= discard_q - CW'(1);
      end
    end
  end

  // Address queue: fetch addresses of live requests, in issue order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aq_rd_q <= '0;
      aq_wr_q <= '0;
    end else if (ct_trans_i) begin
      aq_rd_q <= '0;
      aq_wr_q <= '0;
    end else begin
      if (grant) aq_wr_q <= aq_wr_q + PW'(1);
      if (push)  aq_rd_q <= aq_rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant && !ct_trans_i) aq_mem[aq_wr_q] <= imem_addr_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fifo_rd_q    <= '0;
      fifo_wr_q    <= '0;
      fifo_count_q <= '0;
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        fifo_insn[i] <= '0;
        fifo_addr[i] <= '0;
      end
    end else if (ct_trans_i) begin
      fifo_rd_q    <= '0;
      fifo_wr_q    <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) begin
        fifo_insn[fifo_wr_q] <= imem_rdata_i;
        fifo_addr[fifo_wr_q] <= aq_mem[aq_rd_q];
        fifo_wr_q            <= fifo_wr_q + PW'(1);
      end
      if (pop) fifo_rd_q <= fifo_rd_q + PW'(1);
      fifo_count_q <= fifo_count_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_rv0_fetch.sv
// Self-checking bench for rv0_fetch: a memory model tags requests with a
// redirect epoch and a scoreboard holds the instructions decode should see.
module tb_rv0_fetch;

  localparam logic [31:0] RST_ADDR = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ct_target;
  logic        ct_trans;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_insn;
  logic [31:0] if_addr;
  logic        if_valid;
  logic        if_ready;

  typedef struct {
    logic [31:0] exp_addr;
    logic [31:0] data;
    int          epoch;
  } pend_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] insn;
  } sb_t;

  pend_t       pend[$];
  sb_t         sbq[$];
  logic [31:0] exp_pc;
  int          epoch;
  bit          run_m;
  bit          gnt_en;
  bit          mem_hold;
  int          grant_cnt;
  bit          arm_pop;
  logic [31:0] first_pop_addr;
  logic [31:0] held_addr;
  bit          found;
  int          n_checks = 0;
  int          n_fail = 0;

  rv0_fetch #(.XLEN(32), .RESET_ADDR(RST_ADDR), .IBUF_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ct_target_i(ct_target), .ct_trans_i(ct_trans),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .if_insn_o(if_insn), .if_addr_o(if_addr), .if_valid_o(if_valid),
    .if_ready_i(if_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic bit model_req();
    int live_n = 0;
    foreach (pend[i]) if (pend[i].epoch == epoch) live_n++;
    return run_m && ((live_n + sbq.size()) < 2) && (pend.size() < 4);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    sbq.delete();
    exp_pc = RST_ADDR;
    epoch  = 0;
    run_m  = 1'b0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic applyStimulus();
    bit    resp, grant, pop;
    pend_t e;
    resp        = !mem_hold && (pend.size() > 0);
    imem_rvalid = resp;
    imem_rdata  = resp ? pend[0].data : 32'h0;
    imem_gnt    = gnt_en;
    #1;
    if (run_m) begin
      checkOutput("imem_req", {31'b0, imem_req}, {31'b0, model_req()});
      if (model_req()) checkOutput("imem_addr", imem_addr, exp_pc);
    end else begin
      checkOutput("imem_req_boot", {31'b0, imem_req}, 32'h0);
    end
    checkOutput("if_valid", {31'b0, if_valid}, {31'b0, (sbq.size() > 0) && !ct_trans});
    pop   = if_valid && if_ready;
    grant = imem_req && imem_gnt;
    if (pop && sbq.size() > 0) begin
      checkOutput("if_addr", if_addr, sbq[0].addr);
      checkOutput("if_insn", if_insn, sbq[0].insn);
      if (arm_pop) begin
        first_pop_addr = if_addr;
        arm_pop = 1'b0;
      end
      void'(sbq.pop_front());
    end
    if (resp) begin
      e = pend.pop_front();
      if (e.epoch == epoch && !ct_trans) sbq.push_back('{e.exp_addr, mem_word(e.exp_addr)});
    end
    if (grant) begin
      pend.push_back('{exp_pc, mem_word(imem_addr), epoch});
      exp_pc = exp_pc + 32'd4;
      grant_cnt++;
    end
    if (ct_trans) begin
      sbq.delete();
      epoch++;
      exp_pc = ct_target & 32'hFFFF_FFFC;
    end
    run_m = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic redirect(input logic [31:0] target);
    ct_trans  = 1'b1;
    ct_target = target;
    applyStimulus();
    ct_trans  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ct_trans = 1'b0; ct_target = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
    gnt_en = 1'b0; mem_hold = 1'b0; arm_pop = 1'b0; grant_cnt = 0;
    first_pop_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_req", {31'b0, imem_req}, 32'h0);
    checkOutput("rst_addr", imem_addr, RST_ADDR);
    checkOutput("rst_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("rst_insn", if_insn, 32'h0);
    checkOutput("rst_if_addr", if_addr, 32'h0);

    // Boot with a zero-wait memory and decode always ready.
    @(negedge clk);
    rst_n = 1'b1; gnt_en = 1'b1; if_ready = 1'b1;
    steps(3);
    checkOutput("first_valid", {31'b0, if_valid}, 32'h1);
    checkOutput("first_addr", if_addr, RST_ADDR);
    steps(10);

    // Decode stalled: buffer fills after exactly two grants.
    gnt_en = 1'b0;
    steps(5);
    if_ready = 1'b0; gnt_en = 1'b1; grant_cnt = 0;
    steps(6);
    checkOutput("grants_full", grant_cnt, 32'd2);
    checkOutput("req_full", {31'b0, imem_req}, 32'h0);
    if_ready = 1'b1;
    applyStimulus();
    if_ready = 1'b0;
    applyStimulus();
    checkOutput("grants_after_pop", grant_cnt, 32'd3);

    // Two outstanding requests killed by a redirect before any response.
    gnt_en = 1'b0;
    redirect(32'h0000_0200);
    steps(2);
    mem_hold = 1'b1; gnt_en = 1'b1; if_ready = 1'b1; grant_cnt = 0;
    steps(3);
    checkOutput("grants_held", grant_cnt, 32'd2);
    gnt_en = 1'b0;
    redirect(32'h0000_0400);
    mem_hold = 1'b0; gnt_en = 1'b1; arm_pop = 1'b1;
    steps(8);
    checkOutput("after_redirect_400", first_pop_addr, 32'h0000_0400);

    // Redirect landing on a cycle with both a grant and a response.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (model_req() && gnt_en && pend.size() > 0 && !mem_hold) found = 1'b1;
      else applyStimulus();
    end
    checkOutput("found_grant_resp_cycle", {31'b0, found}, 32'h1);
    redirect(32'h0000_0082);
    arm_pop = 1'b1;
    steps(8);
    checkOutput("after_redirect_80", first_pop_addr, 32'h0000_0080);

    // Grant withheld: request stays stable until a redirect replaces it.
    gnt_en = 1'b0;
    steps(4);
    grant_cnt = 0;
    held_addr = exp_pc;
    steps(2);
    checkOutput("held_addr", imem_addr, held_addr);
    checkOutput("held_req", {31'b0, imem_req}, 32'h1);
    redirect(32'h0000_0300);
    checkOutput("redirect_addr", imem_addr, 32'h0000_0300);
    steps(2);
    checkOutput("no_grant_held", grant_cnt, 32'd0);

    // PC wraps at the top of the address space.
    gnt_en = 1'b1;
    redirect(32'hFFFF_FFFC);
    applyStimulus();
    checkOutput("wrap_addr", imem_addr, 32'h0000_0000);
    steps(3);

    // Asynchronous reset in the middle of a burst.
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_req", {31'b0, imem_req}, 32'h0);
    checkOutput("midrst_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("midrst_addr", imem_addr, RST_ADDR);
    imem_rvalid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    steps(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
